uio_bus_arbiter: RTL and testbench

UIO_BUS_ARBITER -- requirements
Module: uio_bus_arbiter

---
 rtl/uio_arb_pkg.sv | 18 +
 rtl/uio_bus_arbiter.sv | 115 +++++++++++
 tb/tb_uio_bus_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/uio_arb_pkg.sv
// Shared types and default parameters for the two-requester uio bus arbiter.
package uio_arb_pkg;

    localparam int unsigned BURST_DEF    = 4;
    localparam int unsigned TURN_CYC_DEF = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TURN = 2'd1,
        XFER = 2'd2
    } state_t;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_t;

endpackage : uio_arb_pkg

// File: rtl/uio_bus_arbiter.sv
// Round-robin arbiter sharing one bidirectional uio pad bus between two requesters,
// with a bus-turnaround gap before each grant and bursts capped at BURST beats.
module uio_bus_arbiter
    import uio_arb_pkg::*;
#(
    parameter int unsigned BURST    = BURST_DEF,
    parameter int unsigned TURN_CYC = TURN_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       req_a,
    input  logic       req_b,
    input  logic       wr_a,
    input  logic       wr_b,
    input  logic [7:0] wdata_a,
    input  logic [7:0] wdata_b,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic       beat,
    output logic [7:0] rdata,
    output logic       rvalid,
    output logic       busy
);

    state_t     state;
    owner_t     owner;
    owner_t     last;
    owner_t     pick;
    logic       dir;
    logic [3:0] beat_cnt;
    logic [1:0] turn_cnt;

    logic       own_req;
    logic [7:0] own_wdata;
    logic       in_xfer;
    logic       drive;
    logic       last_beat;

    // Owner-side views and round-robin choice for the next selection.
    always_comb begin
        own_req   = (owner == OWN_A) ? req_a : req_b;
        own_wdata = (owner == OWN_A) ? wdata_a : wdata_b;
        pick      = OWN_A;
        if (req_a && req_b) begin
            pick = (last == OWN_A) ? OWN_B : OWN_A;
        end else if (req_b) begin
            pick = OWN_B;
        end
    end

    assign in_xfer   = (state == XFER);
    assign drive     = in_xfer && dir;
    assign last_beat = (beat_cnt == 4'(BURST - 1));

    // Bus-facing decode; the write path is combinational from the owner's data.
    assign busy    = (state != IDLE);
    assign gnt_a   = in_xfer && (owner == OWN_A);
    assign gnt_b   = in_xfer && (owner == OWN_B);
    assign beat    = in_xfer && own_req;
    assign uio_oe  = drive ? 8'hFF : 8'h00;
    assign uio_out = drive ? own_wdata : 8'h00;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner    <= OWN_A;
            last     <= OWN_B;
            dir      <= 1'b0;
            beat_cnt <= 4'd0;
            turn_cnt <= 2'd0;
            rdata    <= 8'h00;
            rvalid   <= 1'b0;
        end else begin
            rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (ena && (req_a || req_b)) begin
                        owner    <= pick;
                        last     <= pick;
                        dir      <= (pick == OWN_A) ? wr_a : wr_b;
                        beat_cnt <= 4'd0;
                        turn_cnt <= 2'(TURN_CYC - 1);
                        state    <= TURN;
                    end
                end
                TURN: begin
                    if (turn_cnt == 2'd0) begin
                        state <= XFER;
                    end else begin
                        turn_cnt <= turn_cnt - 2'd1;
                    end
                end
                XFER: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + 4'd1;
                        if (!dir) begin
                            rdata  <= uio_in;
                            rvalid <= 1'b1;
                        end
                    end
                    // A beat in a cycle with ena=0 still completes before leaving.
                    if (!own_req || !ena || last_beat) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule : uio_bus_arbiter

// File: tb/tb_uio_bus_arbiter.sv
// Directed bench for uio_bus_arbiter: per-scenario tasks with hand-computed cycle tables.
module tb_uio_bus_arbiter;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       req_a, req_b;
    logic       wr_a, wr_b;
    logic [7:0] wdata_a, wdata_b;
    logic [7:0] uio_in;
    logic [7:0] uio_out, uio_oe;
    logic       gnt_a, gnt_b, beat;
    logic [7:0] rdata;
    logic       rvalid;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // {busy, gnt_a, gnt_b, beat, uio_oe, uio_out}
    logic [19:0] obs;
    assign obs = {busy, gnt_a, gnt_b, beat, uio_oe, uio_out};

    uio_bus_arbiter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .req_a   (req_a),
        .req_b   (req_b),
        .wr_a    (wr_a),
        .wr_b    (wr_b),
        .wdata_a (wdata_a),
        .wdata_b (wdata_b),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .gnt_a   (gnt_a),
        .gnt_b   (gnt_b),
        .beat    (beat),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Leaves rst_n low after two edges; the caller releases it with its own inputs.
    task automatic apply_reset();
        rst_n = 1'b0; ena = 1'b1;
        req_a = 1'b0; req_b = 1'b0; wr_a = 1'b0; wr_b = 1'b0;
        wdata_a = 8'h00; wdata_b = 8'h00; uio_in = 8'h00;
        cyc();
        cyc();
    endtask

    task automatic test_reset();
        apply_reset();
        req_a = 1'b1; req_b = 1'b1; wr_a = 1'b1; wdata_a = 8'hEE; uio_in = 8'h99;
        for (int c = 0; c < 2; c++) begin
            cyc();
            #1;
            checks++;
            if (obs !== 20'h0 || rvalid !== 1'b0 || rdata !== 8'h00) begin
                errors++;
                $display("FAIL reset c%0d got obs=%h rvalid=%b rdata=%h want obs=00000 rvalid=0 rdata=00",
                         c, obs, rvalid, rdata);
            end
        end
    endtask

    task automatic test_write();
        logic [19:0] e;
        apply_reset();
        rst_n = 1'b1; req_a = 1'b1; wr_a = 1'b1; wdata_a = 8'h5A;
        for (int c = 0; c < 7; c++) begin
            if (c == 6) req_a = 1'b0;
            if (c == 1)               e = {1'b1, 3'b000, 16'h0000};
            else if (c >= 2 && c < 6) e = {1'b1, 3'b101, 8'hFF, 8'h5A};
            else                      e = 20'h0;
            #1;
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL write c%0d got %h want %h", c, obs, e);
            end
            cyc();
        end
    endtask

    task automatic test_contention();
        logic [19:0] e;
        logic        ob;
        apply_reset();
        rst_n = 1'b1; req_a = 1'b1; req_b = 1'b1; wr_a = 1'b1; wr_b = 1'b1;
        wdata_a = 8'h11; wdata_b = 8'h22;
        for (int g = 0; g < 3; g++) begin
            ob = (g == 1);
            for (int c = 0; c < 6; c++) begin
                if (c == 0)      e = 20'h0;
                else if (c == 1) e = {1'b1, 3'b000, 16'h0000};
                else             e = {1'b1, !ob, ob, 1'b1, 8'hFF, ob ? 8'h22 : 8'h11};
                #1;
                checks++;
                if (obs !== e) begin
                    errors++;
                    $display("FAIL contention g%0d c%0d got %h want %h", g, c, obs, e);
                end
                cyc();
            end
        end
    endtask

    task automatic test_read();
        logic [19:0] e;
        apply_reset();
        rst_n = 1'b1; req_b = 1'b1; wr_b = 1'b0; uio_in = 8'hC3; wdata_b = 8'h66;
        for (int c = 0; c < 8; c++) begin
            if (c == 4) wr_b = 1'b1;
            if (c == 6) req_b = 1'b0;
            if (c == 1)               e = {1'b1, 3'b000, 16'h0000};
            else if (c >= 2 && c < 6) e = {1'b1, 3'b011, 16'h0000};
            else                      e = 20'h0;
            #1;
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL read_bus c%0d got %h want %h", c, obs, e);
            end
            checks++;
            if (c >= 3 && c <= 6) begin
                if (rvalid !== 1'b1 || rdata !== 8'hC3) begin
                    errors++;
                    $display("FAIL read_data c%0d got rvalid=%b rdata=%h want rvalid=1 rdata=c3",
                             c, rvalid, rdata);
                end
            end else if (rvalid !== 1'b0) begin
                errors++;
                $display("FAIL read_valid c%0d got rvalid=%b want 0", c, rvalid);
            end
            cyc();
        end
    endtask

    task automatic test_early_release();
        logic [19:0] e;
        apply_reset();
        rst_n = 1'b1; req_a = 1'b1; req_b = 1'b1; wr_a = 1'b1; wr_b = 1'b1;
        wdata_a = 8'hA1; wdata_b = 8'hB2;
        for (int c = 0; c < 8; c++) begin
            if (c == 4) req_a = 1'b0;
            case (c)
                1, 6:    e = {1'b1, 3'b000, 16'h0000};
                2, 3:    e = {1'b1, 3'b101, 8'hFF, 8'hA1};
                4:       e = {1'b1, 3'b100, 8'hFF, 8'hA1};
                7:       e = {1'b1, 3'b011, 8'hFF, 8'hB2};
                default: e = 20'h0;
            endcase
            #1;
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL early_release c%0d got %h want %h", c, obs, e);
            end
            cyc();
        end
    endtask

    task automatic test_ena_drop();
        logic [19:0] e;
        apply_reset();
        rst_n = 1'b1; req_a = 1'b1; wr_a = 1'b1; wdata_a = 8'h3C;
        for (int c = 0; c < 9; c++) begin
            if (c == 3) ena = 1'b0;
            if (c == 7) ena = 1'b1;
            case (c)
                1, 8:    e = {1'b1, 3'b000, 16'h0000};
                2, 3:    e = {1'b1, 3'b101, 8'hFF, 8'h3C};
                default: e = 20'h0;
            endcase
            #1;
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL ena_drop c%0d got %h want %h", c, obs, e);
            end
            cyc();
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [19:0] e;
        apply_reset();
        rst_n = 1'b1; req_a = 1'b1; wr_a = 1'b1; wdata_a = 8'h77; wdata_b = 8'h88; wr_b = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c == 3) rst_n = 1'b0;
            if (c == 5) begin
                rst_n = 1'b1;
                req_b = 1'b1;
            end
            case (c)
                1, 6:    e = {1'b1, 3'b000, 16'h0000};
                2, 3, 7: e = {1'b1, 3'b101, 8'hFF, 8'h77};
                default: e = 20'h0;
            endcase
            #1;
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL reset_mid c%0d got %h want %h", c, obs, e);
            end
            cyc();
        end
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1;
        req_a = 1'b0; req_b = 1'b0; wr_a = 1'b0; wr_b = 1'b0;
        wdata_a = 8'h00; wdata_b = 8'h00; uio_in = 8'h00;
        #2;
        test_reset();
        test_write();
        test_contention();
        test_read();
        test_early_release();
        test_ena_drop();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_uio_bus_arbiter
